mem_access_unit: RTL and testbench

- MEM-stage load/store unit sitting directly upstream of the data memory. It takes CPU byte-addressed load/store requests (byte/half/word, signed/unsigned) and drives the word-addressed data-memory port.
- Sub-word stores are done as read-modify-write, so memory only ever sees full-word writes.
- Sub-word loads are extracted and extended in this block and returned through a req/done handshake.

---
 rtl/mau_pkg.sv | 48 ++++
 rtl/mau_align.sv | 61 ++++++
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the MEM-stage load/store unit.
//   - access size encodings (SZ_*)
//   - memory write-type constant (SS_WORD: full-word writes only)
//   - FSM state encoding (S_ERR exists only when MAU_MISALIGN_TRAP_EN is defined)
//   - helpers: effective byte offset within a word, misalignment detection
// Configuration macro: MAU_MISALIGN_TRAP_EN
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] SS_WORD = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
`ifdef MAU_MISALIGN_TRAP_EN
        S_ERR    = 3'd5,
`endif
        S_DONE   = 3'd4
    } state_t;

    // Byte offset actually used inside the word. Halves snap to addr[1],
    // words (and the 2'b11 size alias) always start at lane 0.
    function automatic logic [1:0] eff_offset(input logic [1:0] sz, input logic [1:0] lo);
        logic [1:0] off;
        case (sz)
            SZ_BYTE: off = lo;
            SZ_HALF: off = {lo[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        logic mis;
        case (sz)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mau_align.sv
// mau_align: combinational lane steering for the load/store unit.
//   mem_word   in  32  word read from data memory
//   offset     in  2   effective byte offset (already aligned for the size)
//   size       in  2   SZ_BYTE / SZ_HALF / word (2'b11 behaves as word)
//   sign_ext   in  1   load extension: 1 sign, 0 zero
//   wdata      in  32  store data, sub-words taken from the low bits
//   load_data  out 32  extracted and extended load result
//   store_data out 32  mem_word with the store sub-word merged in
module mau_align
    import mau_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        half_sel = offset[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        store_data = mem_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    store_data[7:0]   = wdata[7:0];
                    2'd1:    store_data[15:8]  = wdata[7:0];
                    2'd2:    store_data[23:16] = wdata[7:0];
                    default: store_data[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) store_data[31:16] = wdata[15:0];
                else           store_data[15:0]  = wdata[15:0];
            end
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit in front of a word-addressed
// data memory. Sub-word stores are read-modify-write so memory only sees
// full-word writes; sub-word loads are extracted/extended here.
// Configuration macro: MAU_MISALIGN_TRAP_EN (defined: misaligned accesses
// complete with err=1 through S_ERR; undefined: they are force-aligned).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req, we, size, sign_ext     request handshake and attributes
//   addr, wdata                 byte address, store data
//   ready, done, err, rdata     acceptance, completion pulse, misalign flag, load result
//   dm_r, dm_w, dm_addr         memory read/write enables, word address
//   dm_wdata, dm_rdata          memory write data, combinational read data
//   special_store_signal        memory write type (always full word)
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              dm_r,
    output logic              dm_w,
    output logic [1:0]        special_store_signal,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata
);

    state_t            state, state_next;
    logic [1:0]        lat_size;
    logic [1:0]        lat_off;
    logic              lat_sign;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] store_merged;

    // Address bits above the memory window wrap and are deliberately dropped.
    logic addr_hi_unused;
    assign addr_hi_unused = ^addr[31:ADDR_W+2];

    assign special_store_signal = SS_WORD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Outputs decode from the state register only, so dm_w falls as soon as
    // reset clears the state, before any further clock edge.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        dm_r       = 1'b0;
        dm_w       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
`ifdef MAU_MISALIGN_TRAP_EN
                    if (is_misaligned(size, addr[1:0]))
                        state_next = S_ERR;
                    else
`endif
                    if (!we)
                        state_next = S_RD;
                    else if (size == SZ_BYTE || size == SZ_HALF)
                        state_next = S_RMW_RD;
                    else
                        state_next = S_WR;
                end
            end
            S_RD: begin
                dm_r       = 1'b1;
                state_next = S_DONE;
            end
            S_RMW_RD: begin
                dm_r       = 1'b1;
                state_next = S_WR;
            end
            S_WR: begin
                dm_w       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
`ifdef MAU_MISALIGN_TRAP_EN
            S_ERR: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

`ifdef MAU_MISALIGN_TRAP_EN
    assign err = (state == S_ERR);
`else
    assign err = 1'b0;
`endif

    mau_align u_align (
        .mem_word   (dm_rdata),
        .offset     (lat_off),
        .size       (lat_size),
        .sign_ext   (lat_sign),
        .wdata      (lat_wdata),
        .load_data  (load_ext),
        .store_data (store_merged)
    );

    // Request latch: dm_addr is captured once here and held for the whole
    // transaction. Word stores get their write data now; sub-word stores
    // overwrite it with the merged word during S_RMW_RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_size  <= SZ_BYTE;
            lat_off   <= 2'b00;
            lat_sign  <= 1'b0;
            lat_wdata <= '0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            rdata     <= '0;
        end else begin
            if (req && ready) begin
                lat_size  <= size;
                lat_off   <= eff_offset(size, addr[1:0]);
                lat_sign  <= sign_ext;
                lat_wdata <= wdata;
                dm_addr   <= addr[ADDR_W+1:2];
                if (we) dm_wdata <= wdata;
            end
            if (state == S_RD)     rdata    <= load_ext;
            if (state == S_RMW_RD) dm_wdata <= store_merged;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven bench for mem_access_unit with a simple
// word-addressed memory model, plus hand sequences for reset-in-write and
// back-to-back requests. Expectations adapt to MAU_MISALIGN_TRAP_EN.
module tb_mem_access_unit;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              sign_ext = 1'b0;
    logic [31:0]       addr = '0;
    logic [31:0]       wdata = '0;
    logic              ready, done, err, dm_r, dm_w;
    logic [31:0]       rdata, dm_wdata, dm_rdata;
    logic [1:0]        special_store_signal;
    logic [ADDR_W-1:0] dm_addr;

    logic [31:0]       mem [0:2047];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [31:0]       pre_data = '0;

    int total = 0;
    int bad = 0;
    int both_cnt = 0;
    int ss_cnt = 0;

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req                  (req),
        .we                   (we),
        .size                 (size),
        .sign_ext             (sign_ext),
        .addr                 (addr),
        .wdata                (wdata),
        .ready                (ready),
        .done                 (done),
        .err                  (err),
        .rdata                (rdata),
        .dm_r                 (dm_r),
        .dm_w                 (dm_w),
        .special_store_signal (special_store_signal),
        .dm_addr              (dm_addr),
        .dm_wdata             (dm_wdata),
        .dm_rdata             (dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) begin
        if (pre_we)    mem[pre_addr] <= pre_data;
        else if (dm_w) mem[dm_addr]  <= dm_wdata;
    end

    always @(negedge clk) begin
        if (dm_r && dm_w) both_cnt++;
        if (special_store_signal != 2'b00) ss_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one request from a negedge; returns edges from accept (inclusive)
    // to the done cycle, and dm_r/dm_w cycle counts over the transaction.
    task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output int nr, output int nw,
                          output logic e, output logic [31:0] rd,
                          output logic [ADDR_W-1:0] wa);
        int g;
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        g = 0;
        while (!ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1 req = 1'b0;
        lat = 1; nr = 0; nw = 0;
        @(negedge clk);
        forever begin
            nr += int'(dm_r);
            nw += int'(dm_w);
            if (done || lat >= 10) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        e = err; rd = rdata; wa = dm_addr;
    endtask

    typedef struct {
        logic              w;
        logic [1:0]        sz;
        logic              sx;
        logic [31:0]       a;
        logic [31:0]       wd;
        logic [31:0]       rd;
        logic              e;
        int                lat;
        int                nr;
        int                nw;
        logic [ADDR_W-1:0] wa;
        logic [31:0]       mw;
    } vec_t;

    vec_t vt [17];

    initial begin
        int lat, nr, nw;
        logic e;
        logic [31:0] rd;
        logic [ADDR_W-1:0] wa;
        logic [6:0] exp_ready, exp_done;

        //        w     sz     sx    addr          wdata          rdata after   err  lat nr nw wa       mem[wa]
        vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 0, 1, 11'd4, 32'hDEAD_BEEF};
        vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1, 0, 11'd4, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h80FF_1234, 32'hDEAD_BEEF, 1'b0, 2, 0, 1, 11'd4, 32'h80FF_1234};
        vt[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 1, 0, 11'd4, 32'h80FF_1234};
        vt[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0080, 1'b0, 2, 1, 0, 11'd4, 32'h80FF_1234};
        vt[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'hFFFF_80FF, 1'b0, 2, 1, 0, 11'd4, 32'h80FF_1234};
        vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_1234, 1'b0, 2, 1, 0, 11'd4, 32'h80FF_1234};
        vt[7]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         32'h0000_0012, 1'b0, 2, 1, 0, 11'd4, 32'h80FF_1234};
        vt[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h1234_56AA, 32'h0000_0012, 1'b0, 3, 1, 1, 11'd8, 32'h1122_AA44};
        vt[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'hFFFF_BEEF, 32'h0000_0012, 1'b0, 3, 1, 1, 11'd8, 32'hBEEF_AA44};
        vt[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hBEEF_AA44, 1'b0, 2, 1, 0, 11'd8, 32'hBEEF_AA44};
`ifdef MAU_MISALIGN_TRAP_EN
        vt[11] = '{1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0,         32'hBEEF_AA44, 1'b1, 1, 0, 0, 11'd0, 32'hCAFE_5678};
        vt[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         32'hBEEF_AA44, 1'b1, 1, 0, 0, 11'd1, 32'h0BAD_F00D};
        vt[13] = '{1'b1, 2'b01, 1'b0, 32'h0000_0023, 32'h0000_7777, 32'hBEEF_AA44, 1'b1, 1, 0, 0, 11'd8, 32'hBEEF_AA44};
        vt[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hBEEF_AA44, 1'b0, 2, 1, 0, 11'd8, 32'hBEEF_AA44};
        vt[15] = '{1'b0, 2'b10, 1'b0, 32'h0000_2020, 32'h0,         32'hBEEF_AA44, 1'b0, 2, 1, 0, 11'd8, 32'hBEEF_AA44};
`else
        vt[11] = '{1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0,         32'h0000_5678, 1'b0, 2, 1, 0, 11'd0, 32'hCAFE_5678};
        vt[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         32'h0BAD_F00D, 1'b0, 2, 1, 0, 11'd1, 32'h0BAD_F00D};
        vt[13] = '{1'b1, 2'b01, 1'b0, 32'h0000_0023, 32'h0000_7777, 32'h0BAD_F00D, 1'b0, 3, 1, 1, 11'd8, 32'h7777_AA44};
        vt[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h7777_AA44, 1'b0, 2, 1, 0, 11'd8, 32'h7777_AA44};
        vt[15] = '{1'b0, 2'b10, 1'b0, 32'h0000_2020, 32'h0,         32'h7777_AA44, 1'b0, 2, 1, 0, 11'd8, 32'h7777_AA44};
`endif
        vt[16] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h80FF_1234, 1'b0, 2, 1, 0, 11'd4, 32'h80FF_1234};

        // Memory image loaded while the DUT is held in reset.
        preload(11'd0,  32'hCAFE_5678);
        preload(11'd1,  32'h0BAD_F00D);
        preload(11'd8,  32'h1122_3344);
        preload(11'd12, 32'h5555_5555);

        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_dm_rw", {30'd0, dm_r, dm_w}, 32'd0);
        check("rst_dm_addr", {21'd0, dm_addr}, 32'd0);
        check("rst_dm_wdata", dm_wdata, 32'd0);
        check("rst_ss", {30'd0, special_store_signal}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            run_op(vt[i].w, vt[i].sz, vt[i].sx, vt[i].a, vt[i].wd, lat, nr, nw, e, rd, wa);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            check($sformatf("v%0d_rdata", i), rd, vt[i].rd);
            check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vt[i].e});
            check($sformatf("v%0d_nr", i), 32'(nr), 32'(vt[i].nr));
            check($sformatf("v%0d_nw", i), 32'(nw), 32'(vt[i].nw));
            check($sformatf("v%0d_dm_addr", i), {21'd0, wa}, {21'd0, vt[i].wa});
            check($sformatf("v%0d_mem", i), mem[vt[i].wa], vt[i].mw);
        end

        // Back-to-back loads with req held high throughout.
        exp_ready = 7'b1001001;  // bit c = cycle c
        exp_done  = 7'b0100100;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10; wdata = '0;
        for (int c = 0; c < 7; c++) begin
            check($sformatf("b2b_ready_c%0d", c), {31'd0, ready}, {31'd0, exp_ready[c]});
            check($sformatf("b2b_done_c%0d", c), {31'd0, done}, {31'd0, exp_done[c]});
            if (c == 6) req = 1'b0;
            @(negedge clk);
        end
        check("b2b_rdata", rdata, 32'h80FF_1234);
        check("b2b_idle", {31'd0, ready}, 32'd1);

        // Reset asserted while the word write is on the memory port.
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h30; wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("rst_wr_dm_w_before", {31'd0, dm_w}, 32'd1);
        check("rst_wr_dm_wdata", dm_wdata, 32'h1234_5678);
        #1 rst_n = 1'b0;
        #1;
        check("rst_wr_dm_w_async", {31'd0, dm_w}, 32'd0);
        check("rst_wr_ready_async", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        check("rst_wr_mem_kept", mem[12], 32'h5555_5555);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wr_ready_after", {31'd0, ready}, 32'd1);
        check("rst_wr_rdata_cleared", rdata, 32'd0);
        run_op(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, nr, nw, e, rd, wa);
        check("rst_wr_reload_lat", 32'(lat), 32'd2);
        check("rst_wr_reload_rdata", rd, 32'h5555_5555);

        check("never_r_and_w", 32'(both_cnt), 32'd0);
        check("ss_always_word", 32'(ss_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
